game_period_ctrl: RTL and testbench
===================================

# game_period_ctrl

Level sequencer at the controller end of the prelim/game handshake: issues the one-cycle `prelimSig` that starts a preliminary countdown and consumes the returning `gameSig`. It then runs the timed game period, judges the player's answer, and advances `curLevel`, retries the level, or ends the game. It drives the level and lives digits on two 7-segment positions.

## Interface
- `GAME_SECS`, 9: game-period length in seconds. Range 1..15.
- `MAX_LEVEL`, 9: last level. Range 1..9.
- `LIVES`, 3: misses allowed before game over. Range 1..9. Used only with `LIVES_EN`.

Ports:
- `Clk100M`  in  1: system clock. All logic on its rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `Clk1Hz`  in  1: 1 Hz square wave. Passes through a 2-flop synchronizer, then a rising-edge detect that produces an internal one-cycle `tick`.
- `startBtn`  in  1: debounced one-cycle start request.
- `gameSig`  in  1: from the prelim block. A rising edge means the prelim countdown has finished.
- `answerValid`  in  1: one-cycle strobe carrying the player's answer.
- `answerCorrect`  in  1: answer verdict. Meaningful only when `answerValid` is high.
- `prelimSig`  out  1: one-cycle request to start the prelim countdown.
- `curLevel`  out  4: current level, 1..`MAX_LEVEL`.
- `secsLeft`  out  4: remaining game seconds.
- `gameActive`  out  1: high while in state GAME.
- `gameOver`  out  1: high in state OVER.
- `gameWon`  out  1: high in state WIN.
- `gameSeg0`  out  8: level digit.
- `gameSeg1`  out  8: lives digit.

## Operation
- States: IDLE, PRELIM, GAME, OVER, WIN.
- Segment code:
  - Active-low; bit7 = dp (always 1); bits6..0 = g..a.
  - Digits: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Blank = FF.
- IDLE:
  - `startBtn` → PRELIM. `prelimSig`=1 for one cycle.
- PRELIM:
  - Waits for a `gameSig` rising edge. A `gameSig` level already high on entry is ignored.
  - On the edge → GAME, `secsLeft`=`GAME_SECS`.
- GAME:
  - Each `tick` decrements `secsLeft`.
  - A `tick` with `secsLeft`==1 sets `secsLeft`=0 and counts as a miss.
- Correct answer (`answerValid` & `answerCorrect`):
  - If `curLevel`==`MAX_LEVEL` → WIN; `curLevel` holds.
  - Otherwise `curLevel`+1 → PRELIM, with a `prelimSig` pulse.
- Miss (`answerValid` & !`answerCorrect`, or timeout):
  - Lives decrement.
  - If lives reach 0 → OVER.
  - Otherwise → PRELIM at the same level, with a `prelimSig` pulse.
- Simultaneous `answerValid` and timeout `tick`: the answer takes precedence; the tick is discarded.
- `answerValid` outside GAME is ignored.
- `startBtn` is ignored in PRELIM and GAME.
- OVER / WIN:
  - `secsLeft` and `curLevel` hold.
  - `startBtn` restarts: `curLevel`=1, lives=`LIVES`, `gameOver`/`gameWon` cleared → PRELIM with a `prelimSig` pulse.
- Displays: `gameSeg0` = digit(`curLevel`); `gameSeg1` = digit(lives).

## Timing
- Reset values:
  - State IDLE; `curLevel`=1; lives=`LIVES`; `secsLeft`=0.
  - `prelimSig`, `gameActive`, `gameOver`, `gameWon` all 0.
  - `gameSeg0`=F9; `gameSeg1`=digit(`LIVES`) with `LIVES_EN`, FF without.
- Reset mid-operation restores all reset values at the next edge. Any `prelimSig` in flight is dropped.
- All outputs are registered.
- `prelimSig` rises one cycle after the qualifying `startBtn` or answer/timeout cycle and stays high exactly one cycle.
- `gameActive` rises one cycle after the cycle in which `gameSig` is sampled high, where it was low in the previous cycle.
- Tick latency: `tick` fires 3 `Clk100M` cycles after a `Clk1Hz` rise (2-flop sync plus edge register). `secsLeft` updates on the cycle after `tick`.
- `curLevel`, lives and segment outputs update on the same edge as the state change.
- Lives use a saturating decrement and never underflow below 0.

## Configuration
- `GAME_PERIOD_LIVES_EN`, defined:
  - Lives counter exists per Operation.
  - `gameSeg1` shows the lives digit.
- Not defined:
  - No lives register; any miss → OVER.
  - `gameSeg1` is held at FF.
  - The `LIVES` parameter is unused.

## Test plan
- Reset, then `startBtn` → `prelimSig` high for exactly 1 cycle; `curLevel`=1; `gameSeg0`=F9.
- PRELIM, `gameSig` 0→1 → `gameActive`=1, `secsLeft`=9. Nine ticks with no answer → miss: lives 3→2, `gameSeg1`=A4, `prelimSig` pulse, `curLevel` stays 1.
- GAME at level 4, correct answer → `curLevel`=5, `gameSeg0`=92, `prelimSig` pulse. Correct answer at level 9 → `gameWon`=1, `curLevel`=9, no `prelimSig`.
- Three wrong answers → `gameOver`=1 with `LIVES_EN`. Without `LIVES_EN`, the first wrong answer gives `gameOver`=1 and `gameSeg1`=FF. `startBtn` in OVER → `curLevel`=1, `prelimSig` pulse.
- Wrong `answerValid` coincident with the final tick → exactly one life lost. Correct `answerValid` coincident with the final tick → level advances, no life lost.
- `Reset` pulsed while in GAME at level 6 → next cycle `curLevel`=1, `gameActive`=0, `secsLeft`=0. `gameSig` held high across reset and start → no GAME entry until `gameSig` falls and rises again.

Source files
------------

// File: rtl/game_period_ctrl.sv
// Level sequencer for the prelim/game handshake: runs the timed game period, judges answers,
// advances/retries levels. Optional lives counter enabled by defining GAME_PERIOD_LIVES_EN.
module game_period_ctrl #(
  parameter int unsigned GAME_SECS = 9,
  parameter int unsigned MAX_LEVEL = 9,
  parameter int unsigned LIVES     = 3
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic       Clk1Hz,
  input  logic       startBtn,
  input  logic       gameSig,
  input  logic       answerValid,
  input  logic       answerCorrect,
  output logic       prelimSig,
  output logic [3:0] curLevel,
  output logic [3:0] secsLeft,
  output logic       gameActive,
  output logic       gameOver,
  output logic       gameWon,
  output logic [7:0] gameSeg0,
  output logic [7:0] gameSeg1
);

  typedef enum logic [2:0] {IDLE, PRELIM, GAME, OVER, WIN} state_t;

  localparam logic [3:0] LP_SECS  = 4'(GAME_SECS);
  localparam logic [3:0] LP_MAX   = 4'(MAX_LEVEL);
  localparam logic [3:0] LP_LIVES = 4'(LIVES);

  function automatic logic [7:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 8'hC0;
      4'd1:    f_seg = 8'hF9;
      4'd2:    f_seg = 8'hA4;
      4'd3:    f_seg = 8'hB0;
      4'd4:    f_seg = 8'h99;
      4'd5:    f_seg = 8'h92;
      4'd6:    f_seg = 8'h82;
      4'd7:    f_seg = 8'hF8;
      4'd8:    f_seg = 8'h80;
      4'd9:    f_seg = 8'h90;
      default: f_seg = 8'hFF;
    endcase
  endfunction

  state_t     r_state;
  logic [1:0] r_sync;
  logic       r_sync_d;
  logic       r_tick;
  logic       r_gs_d;
  logic       r_prelim;
  logic [3:0] r_level;
  logic [3:0] r_secs;
  logic       r_active;
  logic       r_over;
  logic       r_won;
  logic [7:0] r_seg0;
  logic [7:0] r_seg1;

  logic w_gs_rise;
  logic w_correct;
  logic w_wrong;
  logic w_timeout;
  logic w_miss;

  assign w_gs_rise = gameSig & ~r_gs_d;
  assign w_correct = answerValid & answerCorrect;
  assign w_wrong   = answerValid & ~answerCorrect;
  // An answer in the same cycle as the final tick wins; the tick is dropped.
  assign w_timeout = r_tick & ~answerValid & (r_secs == 4'd1);
  assign w_miss    = w_wrong | w_timeout;

`ifdef GAME_PERIOD_LIVES_EN
  logic [3:0] r_lives;
  logic [3:0] w_lives_dec;
  assign w_lives_dec = (r_lives == 4'd0) ? 4'd0 : r_lives - 4'd1;
`else
  logic w_unused_lives;
  assign w_unused_lives = ^LP_LIVES;
`endif

  // gameSig history tracks through reset so a level held high is never seen as an edge.
  always_ff @(posedge Clk100M) begin
    r_gs_d <= gameSig;
    if (Reset) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], Clk1Hz};
      r_sync_d <= r_sync[1];
      r_tick   <= r_sync[1] & ~r_sync_d;
    end
  end

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_prelim <= 1'b0;
      r_level  <= 4'd1;
      r_secs   <= '0;
      r_active <= 1'b0;
      r_over   <= 1'b0;
      r_won    <= 1'b0;
      r_seg0   <= f_seg(4'd1);
`ifdef GAME_PERIOD_LIVES_EN
      r_lives  <= LP_LIVES;
      r_seg1   <= f_seg(LP_LIVES);
`else
      r_seg1   <= '1;
`endif
    end else begin
      r_prelim <= 1'b0;
      case (r_state)
        IDLE: begin
          if (startBtn) begin
            r_state  <= PRELIM;
            r_prelim <= 1'b1;
          end
        end
        PRELIM: begin
          if (w_gs_rise) begin
            r_state  <= GAME;
            r_secs   <= LP_SECS;
            r_active <= 1'b1;
          end
        end
        GAME: begin
          if (w_correct) begin
            r_active <= 1'b0;
            if (r_level == LP_MAX) begin
              r_state <= WIN;
              r_won   <= 1'b1;
            end else begin
              r_level  <= r_level + 4'd1;
              r_seg0   <= f_seg(r_level + 4'd1);
              r_state  <= PRELIM;
              r_prelim <= 1'b1;
            end
          end else if (w_miss) begin
            r_active <= 1'b0;
            if (w_timeout) r_secs <= '0;
`ifdef GAME_PERIOD_LIVES_EN
            r_lives <= w_lives_dec;
            r_seg1  <= f_seg(w_lives_dec);
            if (w_lives_dec == 4'd0) begin
              r_state <= OVER;
              r_over  <= 1'b1;
            end else begin
              r_state  <= PRELIM;
              r_prelim <= 1'b1;
            end
`else
            r_state <= OVER;
            r_over  <= 1'b1;
`endif
          end else if (r_tick && (r_secs != 4'd0)) begin
            r_secs <= r_secs - 4'd1;
          end
        end
        OVER, WIN: begin
          if (startBtn) begin
            r_level  <= 4'd1;
            r_seg0   <= f_seg(4'd1);
            r_over   <= 1'b0;
            r_won    <= 1'b0;
            r_state  <= PRELIM;
            r_prelim <= 1'b1;
`ifdef GAME_PERIOD_LIVES_EN
            r_lives  <= LP_LIVES;
            r_seg1   <= f_seg(LP_LIVES);
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign prelimSig  = r_prelim;
  assign curLevel   = r_level;
  assign secsLeft   = r_secs;
  assign gameActive = r_active;
  assign gameOver   = r_over;
  assign gameWon    = r_won;
  assign gameSeg0   = r_seg0;
  assign gameSeg1   = r_seg1;

endmodule

// File: tb/tb_game_period_ctrl.sv
// Bench for game_period_ctrl: directed scenarios plus random event mix, checked against an
// event-level reference model of the game rules.
module tb_game_period_ctrl;

  localparam int GS = 9;
  localparam int ML = 9;
  localparam int LV = 3;
`ifdef GAME_PERIOD_LIVES_EN
  localparam bit LIVES_ON    = 1'b1;
  localparam int START_LIVES = LV;
`else
  localparam bit LIVES_ON    = 1'b0;
  localparam int START_LIVES = 1;
`endif

  localparam int PH_IDLE = 0, PH_PRELIM = 1, PH_GAME = 2, PH_OVER = 3, PH_WIN = 4;

  logic       Clk100M, Reset, Clk1Hz, startBtn, gameSig, answerValid, answerCorrect;
  logic       prelimSig, gameActive, gameOver, gameWon;
  logic [3:0] curLevel, secsLeft;
  logic [7:0] gameSeg0, gameSeg1;

  game_period_ctrl #(.GAME_SECS(GS), .MAX_LEVEL(ML), .LIVES(LV)) dut (
    .Clk100M(Clk100M), .Reset(Reset), .Clk1Hz(Clk1Hz), .startBtn(startBtn),
    .gameSig(gameSig), .answerValid(answerValid), .answerCorrect(answerCorrect),
    .prelimSig(prelimSig), .curLevel(curLevel), .secsLeft(secsLeft),
    .gameActive(gameActive), .gameOver(gameOver), .gameWon(gameWon),
    .gameSeg0(gameSeg0), .gameSeg1(gameSeg1)
  );

  initial Clk100M = 1'b0;
  always #5 Clk100M = ~Clk100M;

  logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int n_vec = 0;
  int n_err = 0;

  int m_phase, m_level, m_lives, m_secs;
  bit m_prelim;

  task automatic step();
    @(posedge Clk100M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":prelimSig"},  prelimSig,  m_prelim);
    chk({ctx, ":curLevel"},   curLevel,   m_level);
    chk({ctx, ":secsLeft"},   secsLeft,   m_secs);
    chk({ctx, ":gameActive"}, gameActive, m_phase == PH_GAME);
    chk({ctx, ":gameOver"},   gameOver,   m_phase == PH_OVER);
    chk({ctx, ":gameWon"},    gameWon,    m_phase == PH_WIN);
    chk({ctx, ":gameSeg0"},   gameSeg0,   seg_tab[m_level]);
    chk({ctx, ":gameSeg1"},   gameSeg1,   LIVES_ON ? seg_tab[m_lives] : 8'hFF);
  endtask

  task automatic model_reset();
    m_phase  = PH_IDLE;
    m_level  = 1;
    m_lives  = START_LIVES;
    m_secs   = 0;
    m_prelim = 0;
  endtask

  task automatic model_miss();
    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    if (m_lives == 0) m_phase = PH_OVER;
    else begin
      m_phase  = PH_PRELIM;
      m_prelim = 1;
    end
  endtask

  task automatic model_answer(input bit correct);
    if (m_phase != PH_GAME) return;
    if (!correct) model_miss();
    else if (m_level == ML) m_phase = PH_WIN;
    else begin
      m_level  = m_level + 1;
      m_phase  = PH_PRELIM;
      m_prelim = 1;
    end
  endtask

  task automatic settle(input string ctx);
    step();
    m_prelim = 0;
    check_all(ctx);
  endtask

  task automatic reset_dut();
    Reset = 1;
    step();
    model_reset();
    check_all("reset");
    Reset = 0;
  endtask

  task automatic press_start();
    startBtn = 1;
    step();
    startBtn = 0;
    if (m_phase == PH_IDLE || m_phase == PH_OVER || m_phase == PH_WIN) begin
      m_phase  = PH_PRELIM;
      m_level  = 1;
      m_lives  = START_LIVES;
      m_prelim = 1;
    end
    check_all("start");
    settle("start_after");
  endtask

  task automatic set_gamesig(input bit v);
    bit prev;
    prev    = gameSig;
    gameSig = v;
    step();
    if (v && !prev && m_phase == PH_PRELIM) begin
      m_phase = PH_GAME;
      m_secs  = GS;
    end
    check_all("gamesig");
  endtask

  task automatic enter_game();
    if (gameSig) set_gamesig(0);
    set_gamesig(1);
  endtask

  task automatic answer(input bit correct);
    answerValid   = 1;
    answerCorrect = correct;
    step();
    answerValid   = 0;
    answerCorrect = 0;
    model_answer(correct);
    check_all("answer");
    settle("answer_after");
  endtask

  // One Clk1Hz period; optional answer lands in the same cycle the tick is seen.
  task automatic one_second(input bit with_ans, input bit correct);
    Clk1Hz = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("sec_wait");
    end
    answerValid   = with_ans;
    answerCorrect = correct;
    step();
    answerValid   = 0;
    answerCorrect = 0;
    if (with_ans) model_answer(correct);
    else if (m_phase == PH_GAME) begin
      if (m_secs == 1) begin
        m_secs = 0;
        model_miss();
      end else if (m_secs > 1) m_secs = m_secs - 1;
    end
    check_all("sec_tick");
    settle("sec_after");
    Clk1Hz = 0;
    for (int i = 0; i < 3; i++) step();
    check_all("sec_low");
  endtask

  task automatic climb_to(input int target);
    for (int k = 0; k < 60 && !(m_phase == PH_GAME && m_level == target); k++) begin
      if (m_phase == PH_PRELIM) enter_game();
      else if (m_phase == PH_GAME) answer(1);
      else press_start();
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1; Clk1Hz = 0; startBtn = 0; gameSig = 0; answerValid = 0; answerCorrect = 0;
    model_reset();
    step();
    reset_dut();

    // Start, prelim pulse, game entry, full timeout.
    press_start();
    enter_game();
    for (int s = 0; s < GS; s++) one_second(0, 0);

    // Climb to the last level and win.
    climb_to(ML);
    answer(1);
    press_start();

    // Wrong answers until game over.
    for (int w = 0; w < LV && m_phase != PH_OVER; w++) begin
      if (m_phase == PH_PRELIM) enter_game();
      answer(0);
    end
    press_start();

    // Wrong answer coincident with final tick.
    enter_game();
    for (int s = 0; s < GS - 1; s++) one_second(0, 0);
    one_second(1, 0);
    if (m_phase == PH_OVER) press_start();

    // Correct answer coincident with final tick.
    enter_game();
    for (int s = 0; s < GS - 1; s++) one_second(0, 0);
    one_second(1, 1);

    // Reset in the middle of a game at level 6.
    climb_to(6);
    answerValid = 1; answerCorrect = 0;
    reset_dut();
    answerValid = 0;

    // gameSig held high across reset and start must not start the game.
    if (!gameSig) set_gamesig(1);
    reset_dut();
    press_start();
    set_gamesig(1);
    answer(1);
    set_gamesig(0);
    set_gamesig(1);

    // Random event mix.
    for (int r = 0; r < 80; r++) begin
      case ($urandom_range(0, 5))
        0: press_start();
        1: set_gamesig(!gameSig);
        2: one_second(0, 0);
        3: one_second(1, 1'($urandom_range(0, 1)));
        4: answer(1'($urandom_range(0, 1)));
        default: begin
          step();
          check_all("idle");
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
